// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/DM memory port arbiter.
//   arb_state_t : arbiter FSM state (IDLE -> ACCESS -> DONE -> IDLE)
//   arb_owner_t : which requester owns the current access
//   MEM_DELAY_DEFAULT : default memory latency taken from `MEM_DELAY_CONST
`ifndef MEM_DELAY_CONST
`define MEM_DELAY_CONST 3
`endif

package mem_arb_pkg;

  localparam int unsigned MEM_DELAY_DEFAULT = `MEM_DELAY_CONST;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } arb_owner_t;

endpackage

// File: rtl/mem_lat_counter.sv
// Memory latency down-counter.
//   clk, nrst : clock, asynchronous active-low reset
//   load      : load load_val (has priority over dec)
//   load_val  : value loaded on load
//   dec       : decrement by one, holds at zero
//   zero      : counter currently equals zero
module mem_lat_counter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported fixed-latency memory between fetch (IF) and data (DM).
//   clk, nrst                  : clock, asynchronous active-low reset
//   if_req/if_addr/if_flush    : fetch request, address, cancel of in-flight fetch
//   if_rdata/if_valid/if_stall : fetched word, one-cycle completion pulse, IF wait line
//   dm_req/dm_we/dm_addr/dm_wdata : data request (store when dm_we)
//   dm_rdata/dm_valid/dm_stall : load word, one-cycle completion pulse, DM wait line
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory side
// DM wins arbitration unless IF has already lost STARVE_MAX grants in a row.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_DELAY  = MEM_DELAY_DEFAULT,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W    = $clog2(MEM_DELAY) + 1;
  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  arb_state_t          state_q, state_d;
  arb_owner_t          owner_q, owner_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                cancel_q, cancel_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   if_rdata_q, dm_rdata_q;

  logic cnt_load, cnt_dec, cnt_zero;
  logic latch, grant_if, last_access;
  logic capture_if, capture_dm;

  mem_lat_counter #(
    .WIDTH (CNT_W)
  ) u_lat_counter (
    .clk      (clk),
    .nrst     (nrst),
    .load     (cnt_load),
    .load_val (CNT_W'(MEM_DELAY - 1)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign grant_if = if_req & (~dm_req | (starve_q == STARVE_W'(STARVE_MAX)));

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    cancel_d = cancel_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    latch    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cancel_d = 1'b0;
        if (if_req || dm_req) begin
          latch    = 1'b1;
          cnt_load = 1'b1;
          state_d  = ACCESS;
          if (grant_if) begin
            owner_d  = OWN_IF;
            starve_d = '0;
          end else begin
            owner_d = OWN_DM;
            if (!if_req) begin
              starve_d = '0;
            end else if (starve_q != STARVE_W'(STARVE_MAX)) begin
              starve_d = starve_q + STARVE_W'(1);
            end
          end
        end
      end
      ACCESS: begin
        cnt_dec = 1'b1;
        if ((owner_q == OWN_IF) && if_flush) begin
          cancel_d = 1'b1;
        end
        if (cnt_zero) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Flag only matters while not in IDLE; DONE always returns there.
        cancel_d = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign last_access = (state_q == ACCESS) && cnt_zero;
  // A flush arriving on the capture cycle itself must also block the update.
  assign capture_if  = last_access && (owner_q == OWN_IF) && !cancel_q && !if_flush;
  assign capture_dm  = last_access && (owner_q == OWN_DM) && !we_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      starve_q   <= '0;
      cancel_q   <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      cancel_q <= cancel_d;
      if (latch) begin
        addr_q  <= grant_if ? if_addr : dm_addr;
        we_q    <= grant_if ? 1'b0 : dm_we;
        wdata_q <= grant_if ? '0 : dm_wdata;
      end
      if (capture_if) begin
        if_rdata_q <= mem_rdata;
      end
      if (capture_dm) begin
        dm_rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Same-cycle flush in DONE still suppresses the pulse.
  assign if_valid = (state_q == DONE) && (owner_q == OWN_IF) && !cancel_q && !if_flush;
  assign dm_valid = (state_q == DONE) && (owner_q == OWN_DM);
  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;

  // Gated by nrst so stalls drop the instant reset asserts.
  assign if_stall = nrst & if_req & ~if_valid;
  assign dm_stall = nrst & dm_req & ~dm_valid;

endmodule
